mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the ALU. Consumes the ALU result as either a memory address or a pass-through value.
- Issues load/store requests to the data memory over a valid/ready request channel and a valid response channel.
- Performs byte/halfword alignment, store byte-masking and load sign/zero extension.
- Presents one registered writeback record per accepted operation. Back-pressures the ALU side through in_ready while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented by ALU side
- in_ready  output  1  stage can accept an operation this cycle
- in_is_load  input  1  operation is a load
- in_is_store  input  1  operation is a store (never both with in_is_load)
- in_funct3  input  3  RISC-V funct3 (size/sign)
- in_addr  input  32  ALU Out: effective address, or result for non-memory ops
- in_store_data  input  32  rs2 value for stores
- in_rd  input  5  destination register
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  word-aligned address (bits [1:0] = 0)
- mem_req_wmask  output  4  byte write enables; 0000 = read
- mem_req_wdata  output  32  lane-replicated store data
- mem_resp_valid  input  1  read data valid (single-cycle pulse)
- mem_resp_data  input  32  read word
- wb_valid  output  1  writeback record valid (one-cycle pulse)
- wb_rd  output  5  destination register (0 for stores and errors)
- wb_data  output  32  writeback value
- wb_err  output  1  misaligned access or illegal funct3

Behaviour:
- Reset (async): state IDLE; mem_req_valid, mem_req_wmask, mem_req_addr, mem_req_wdata, wb_valid, wb_rd, wb_data, wb_err all 0; in_ready 1 once in IDLE. Reset mid-transaction abandons it; later mem_resp_valid is ignored.
- States:
  - IDLE: in_ready = 1; accept on in_valid.
  - REQ: mem_req_valid = 1.
  - RESP: awaiting read data.
- in_ready = 1 only in IDLE; 0 in REQ and RESP.
- Accept in IDLE, non-memory op: next cycle wb_valid = 1, wb_data = in_addr, wb_rd = in_rd, wb_err = 0. Stay IDLE. Latency 1.
- Error checks on accept, load or store:
  - Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
  - Any error: no memory request; next cycle wb_valid = 1, wb_err = 1, wb_rd = 0, wb_data = 0. Stay IDLE.
- Legal store: go to REQ.
  - mem_req_addr = {addr[31:2], 00}.
  - wmask: SB = 0001 << addr[1:0]; SH = 0011 << addr[1:0]; SW = 1111.
  - wdata: SB = byte replicated x4; SH = halfword replicated x2; SW = as-is.
- Legal load: go to REQ with wmask = 0000. Latch addr[1:0], funct3 and rd.
- REQ: all mem_req_* outputs held stable until mem_req_ready = 1.
  - On handshake, store: next cycle wb_valid = 1, wb_rd = 0, wb_data = 0; go to IDLE.
  - On handshake, load: go to RESP; mem_req_valid drops next cycle.
- RESP: on mem_resp_valid, extract the lane selected by the latched offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next cycle wb_valid = 1, wb_rd = latched rd, wb_err = 0; go to IDLE.
- Ordering and overlap:
  - Minimum load latency from accept to wb_valid is 3 cycles; minimum store latency is 2 cycles.
  - mem_resp_valid in IDLE or REQ is ignored. mem_req_ready in IDLE or RESP is ignored.
  - New accept is allowed in the same cycle wb_valid of the previous op is high.
- wb_valid is a one-cycle pulse; wb_rd, wb_data and wb_err hold their values until the next record.

Test Plan:
- Non-memory op, in_addr = 0x0000_00FF, rd = 5 -> one cycle later wb_valid = 1, wb_data = 0x0000_00FF, wb_rd = 5, no mem_req_valid.
- SB addr = 0x1003, data = 0x1234_56A7, mem_req_ready stalled 3 cycles -> mem_req_valid held 3 cycles with addr = 0x1000, wmask = 1000, wdata = 0xA7A7_A7A7 stable throughout; then one wb_valid with wb_rd = 0.
- LH addr = 0x2002, resp 0x8001_0000 -> wb_data = 0xFFFF_8001. LHU with same stimulus -> wb_data = 0x0000_8001. LB addr = 0x2001, resp 0x0000_7F00 -> 0x0000_007F.
- LW addr = 0x3002, and SH addr = 0x3001 -> each gives wb_err = 1 with no request; load funct3 = 011 -> wb_err = 1.
- Load with mem_req_ready high immediately and mem_resp_valid 1 cycle later -> wb_valid exactly 3 cycles after accept; in_ready low during REQ and RESP; back-to-back second op accepted the cycle wb_valid is high.
- Reset asserted while in RESP, then a late mem_resp_valid -> no wb_valid, state IDLE, all outputs 0, in_ready = 1.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns ALU results into aligned data-memory
// requests and produces one registered writeback record per accepted operation.
module mem_access_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [3:0]      mem_req_wmask,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state, state_next;
  logic [1:0]      off_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            is_load_q;

  logic            accept, is_mem, funct_ok, misaligned, op_err;
  logic [3:0]      wmask_c;
  logic [XLEN-1:0] wdata_c, shifted, load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    in_ready      = (state == IDLE);
    mem_req_valid = (state == REQ);
    accept        = (state == IDLE) && in_valid;
    is_mem        = in_is_load || in_is_store;

    funct_ok = 1'b0;
    if (in_is_load)
      funct_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                 (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    else if (in_is_store)
      funct_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);

    misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    op_err     = is_mem && (!funct_ok || misaligned);

    case (in_funct3[1:0])
      2'b00:   begin
        wmask_c = 4'b0001 << in_addr[1:0];
        wdata_c = {4{in_store_data[7:0]}};
      end
      2'b01:   begin
        wmask_c = 4'b0011 << in_addr[1:0];
        wdata_c = {2{in_store_data[15:0]}};
      end
      default: begin
        wmask_c = 4'b1111;
        wdata_c = in_store_data;
      end
    endcase

    // Bring the addressed lane down to bit 0, then size/extend it.
    shifted = mem_resp_data >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase

    case (state)
      IDLE: if (accept && is_mem && !op_err) state_next = REQ;
      REQ:  if (mem_req_ready) state_next = is_load_q ? RESP : IDLE;
      RESP: if (mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_addr  <= '0;
      mem_req_wmask <= '0;
      mem_req_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_err        <= 1'b0;
      off_q         <= '0;
      funct3_q      <= '0;
      rd_q          <= '0;
      is_load_q     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (!is_mem) begin
            wb_valid <= 1'b1;
            wb_data  <= in_addr;
            wb_rd    <= in_rd;
            wb_err   <= 1'b0;
          end else if (op_err) begin
            wb_valid <= 1'b1;
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_err   <= 1'b1;
          end else begin
            mem_req_addr  <= {in_addr[XLEN-1:2], 2'b00};
            mem_req_wmask <= in_is_store ? wmask_c : 4'b0000;
            mem_req_wdata <= in_is_store ? wdata_c : '0;
            off_q         <= in_addr[1:0];
            funct3_q      <= in_funct3;
            rd_q          <= in_rd;
            is_load_q     <= in_is_load;
          end
        end
        REQ: if (mem_req_ready && !is_load_q) begin
          wb_valid <= 1'b1;
          wb_data  <= '0;
          wb_rd    <= '0;
          wb_err   <= 1'b0;
        end
        RESP: if (mem_resp_valid) begin
          wb_valid <= 1'b1;
          wb_data  <= load_val;
          wb_rd    <= rd_q;
          wb_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
